// File: rtl/alu_pkg.sv
// Shared constants for the RV32 execute-stage ALU slice.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/alu_exec_unit_if.sv
// EX-stage operand/control bundle and its EX/MEM-facing results.
interface alu_exec_unit_if;
   import alu_pkg::*;

   logic [XLEN-1:0] SrcAE;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] ImmExtE;
   logic [XLEN-1:0] PCE;
   logic            ALUSrcE;
   logic [2:0]      ALUControlE;
   logic            BranchE;
   logic            JumpE;
   logic            ZeroE;
   logic [XLEN-1:0] PCTargetE;
   logic            PCSrcE;
   logic [XLEN-1:0] ALUResultM;
   logic [XLEN-1:0] WriteDataM;

   modport master (
      output SrcAE, RD2E, ImmExtE, PCE, ALUSrcE, ALUControlE, BranchE, JumpE,
      input  ZeroE, PCTargetE, PCSrcE, ALUResultM, WriteDataM
   );

   modport slave (
      input  SrcAE, RD2E, ImmExtE, PCE, ALUSrcE, ALUControlE, BranchE, JumpE,
      output ZeroE, PCTargetE, PCSrcE, ALUResultM, WriteDataM
   );

endinterface

// File: rtl/alu_core.sv
// Combinational RV32 ALU: eight operations plus a zero flag on the result.
module alu_core
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [2:0]      ALUControl,
   output logic [XLEN-1:0] Result,
   output logic            Zero
);

   // Shifts use only the low five bits of B, matching RV32 shamt semantics.
   always_comb begin
      Result = '0;
      case (ALUControl)
         ALU_ADD: Result = SrcA + SrcB;
         ALU_SUB: Result = SrcA - SrcB;
         ALU_AND: Result = SrcA & SrcB;
         ALU_OR:  Result = SrcA | SrcB;
         ALU_XOR: Result = SrcA ^ SrcB;
         ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         ALU_SLL: Result = SrcA << SrcB[4:0];
         ALU_SRL: Result = SrcA >> SrcB[4:0];
         default: Result = '0;
      endcase
   end

   assign Zero = (Result == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: operand-B select, ALU, branch target/decision, EX/MEM registers.
module alu_exec_unit
   import alu_pkg::*;
(
   input  logic           CLK,
   input  logic           RST_N,
   alu_exec_unit_if.slave ex
);

   logic [XLEN-1:0] SrcBE;
   logic [XLEN-1:0] ALUResultE;
   logic            zeroE;

   assign SrcBE = ex.ALUSrcE ? ex.ImmExtE : ex.RD2E;

   alu_core u_alu_core (
      .SrcA       (ex.SrcAE),
      .SrcB       (SrcBE),
      .ALUControl (ex.ALUControlE),
      .Result     (ALUResultE),
      .Zero       (zeroE)
   );

   assign ex.ZeroE     = zeroE;
   assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
   assign ex.PCSrcE    = ex.JumpE | (ex.BranchE & zeroE);

   // Store data always comes from the register operand, never the immediate.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ex.ALUResultM <= '0;
         ex.WriteDataM <= '0;
      end else begin
         ex.ALUResultM <= ALUResultE;
         ex.WriteDataM <= ex.RD2E;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed and random EX operations vs. an arithmetic model.
module tb_alu_exec_unit;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] wd;
   } expM_t;

   logic  CLK;
   logic  RST_N;
   int    assertCount;
   int    failCount;
   expM_t expQ[$];

   alu_exec_unit_if exIf();

   alu_exec_unit dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .ex    (exIf)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference ALU expressed with plain integer arithmetic rather than bit operators where possible.
   function automatic logic [31:0] modelAlu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
      longint unsigned scale;
      int              sa;
      int              sb;
      int unsigned     sh;
      sa    = a;
      sb    = b;
      sh    = b % 32;
      scale = 64'd1;
      for (int i = 0; i < 32; i++)
         if (i < int'(sh)) scale = scale * 64'd2;
      case (op)
         3'd0:    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
         3'd1:    return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
         3'd6:    return 32'((64'(a) * scale) % 64'h1_0000_0000);
         default: return 32'(64'(a) / scale);
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one EX operation, checks the zero-latency outputs and queues the M-stage expectation.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic aluSrc, input logic [2:0] op,
                                input logic br, input logic jmp);
      logic [31:0] r;
      logic [31:0] tgt;
      expM_t       e;
      exIf.SrcAE       = a;
      exIf.RD2E        = rd2;
      exIf.ImmExtE     = imm;
      exIf.PCE         = pc;
      exIf.ALUSrcE     = aluSrc;
      exIf.ALUControlE = op;
      exIf.BranchE     = br;
      exIf.JumpE       = jmp;
      #1;
      r   = modelAlu(a, aluSrc ? imm : rd2, op);
      tgt = 32'((64'(pc) + 64'(imm)) % 64'h1_0000_0000);
      checkOutput("ZeroE", {31'b0, exIf.ZeroE}, {31'b0, r == 32'd0});
      checkOutput("PCTargetE", exIf.PCTargetE, tgt);
      checkOutput("PCSrcE", {31'b0, exIf.PCSrcE}, {31'b0, jmp || (br && r == 32'd0)});
      e.alu = r;
      e.wd  = rd2;
      expQ.push_back(e);
   endtask

   // Monitor: every capture edge out of reset presents the oldest queued operation.
   initial begin
      expM_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (RST_N && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("ALUResultM", exIf.ALUResultM, e.alu);
            checkOutput("WriteDataM", exIf.WriteDataM, e.wd);
         end
      end
   end

   initial begin
      int waitCycles;
      assertCount = 0;
      failCount   = 0;
      RST_N       = 1'b0;
      exIf.SrcAE = '0; exIf.RD2E = '0; exIf.ImmExtE = '0; exIf.PCE = '0;
      exIf.ALUSrcE = 1'b0; exIf.ALUControlE = 3'd0; exIf.BranchE = 1'b0; exIf.JumpE = 1'b0;
      #2;
      checkOutput("resetALUResultM", exIf.ALUResultM, 32'd0);
      checkOutput("resetWriteDataM", exIf.WriteDataM, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      @(negedge CLK) applyStimulus(32'd10, 32'd3, 32'd100, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge CLK) applyStimulus(32'd10, 32'd3, 32'd100, 32'h0, 1'b1, 3'd0, 1'b0, 1'b0);
      @(negedge CLK) applyStimulus(32'h1234, 32'h1234, 32'h0, 32'h40, 1'b0, 3'd1, 1'b1, 1'b0);
      @(negedge CLK) applyStimulus(32'h1234, 32'h1235, 32'h0, 32'h40, 1'b0, 3'd1, 1'b1, 1'b0);
      @(negedge CLK) applyStimulus(32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0, 3'd5, 1'b0, 1'b0);
      @(negedge CLK) applyStimulus(32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 3'd5, 1'b0, 1'b0);
      for (int op = 2; op <= 7; op++) begin
         if (op == 5) continue;
         @(negedge CLK) applyStimulus(32'hF0F0F0F0, 32'h0FF0FF24, 32'h0, 32'h0, 1'b0, 3'(op),
                                      1'b0, 1'b0);
      end
      @(negedge CLK) applyStimulus(32'd1, 32'd2, 32'hFFFFFFF8, 32'h100, 1'b0, 3'd0, 1'b0, 1'b1);
      @(negedge CLK) applyStimulus(32'd0, 32'd0, 32'd8, 32'hFFFFFFFC, 1'b0, 3'd0, 1'b1, 1'b1);

      // Mid-cycle reset with a nonzero value held and another in flight.
      @(negedge CLK) applyStimulus(32'h55, 32'h22, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      @(posedge CLK);
      #3;
      @(negedge CLK) applyStimulus(32'h99, 32'h11, 32'h0, 32'h0, 1'b0, 3'd3, 1'b0, 1'b0);
      #2;
      RST_N = 1'b0;
      expQ.delete();
      #1;
      checkOutput("asyncResetALUResultM", exIf.ALUResultM, 32'd0);
      checkOutput("asyncResetWriteDataM", exIf.WriteDataM, 32'd0);
      @(posedge CLK);
      #2;
      checkOutput("holdResetALUResultM", exIf.ALUResultM, 32'd0);
      checkOutput("holdResetWriteDataM", exIf.WriteDataM, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      applyStimulus(32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         @(negedge CLK) applyStimulus(a, b, $urandom, $urandom, 1'($urandom),
                                      3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      end

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(posedge CLK);
         waitCycles++;
      end
      #2;
      checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
